// File: rtl/tube_pkg.sv
// tube_pkg: shared definitions for the Tube ULA host control-flag block.
//   - FLG_* : bit positions of the seven control flags {T,P,V,M,J,I,Q}
//   - seq_state_e : state encoding shared by both pulse sequencers
//   - default sequencer lengths
//   - apply_write : set/clear-by-mask update of the flag register
package tube_pkg;

    localparam int FLG_Q     = 0;
    localparam int FLG_I     = 1;
    localparam int FLG_J     = 2;
    localparam int FLG_M     = 3;
    localparam int FLG_V     = 4;
    localparam int FLG_P     = 5;
    localparam int FLG_T     = 6;
    localparam int NUM_FLAGS = 7;

    localparam int RST_STRETCH_DEF = 8;
    localparam int CLR_CYCLES_DEF  = 2;

    // One encoding serves both sequencers:
    //   clear sequencer : SEQ_IDLE = IDLE, SEQ_COUNT = CLR
    //   reset sequencer : SEQ_HOLD = RESET, SEQ_COUNT = STRETCH, SEQ_IDLE = RUN
    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_HOLD  = 2'd1,
        SEQ_COUNT = 2'd2
    } seq_state_e;

    // Host write byte: bit 7 is the value S, bits 6:0 select which flags take it.
    function automatic logic [NUM_FLAGS-1:0] apply_write(
        input logic [NUM_FLAGS-1:0] cur,
        input logic [7:0]           wr
    );
        return (cur & ~wr[6:0]) | (wr[6:0] & {NUM_FLAGS{wr[7]}});
    endfunction

endpackage

// File: rtl/tube_pulse_stretch.sv
// tube_pulse_stretch: minimum-width pulse generator with hold, load/reload
// and abort.
//   clk, rst_b  : clock, asynchronous active-low reset
//   hold        : keep the pulse asserted (HOLD); on release counts CYCLES edges
//   load        : (re)start the count of CYCLES edges
//   abort       : drop the pulse at this edge
//   active      : pulse currently asserted (state != IDLE)
//   active_next : value active will take after this edge
// Reset leaves the sequencer counting with RST_CNT edges left, so the pulse
// is asserted during reset and ends RST_CNT+1 edges after release.
module tube_pulse_stretch
    import tube_pkg::*;
#(
    parameter int CYCLES  = 2,
    parameter int RST_CNT = 0
) (
    input  logic clk,
    input  logic rst_b,
    input  logic hold,
    input  logic load,
    input  logic abort,
    output logic active,
    output logic active_next
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(RST_CNT);

    seq_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= SEQ_COUNT;
            cnt   <= CNT_RST;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Priority: abort, then hold, then load; a fresh command always beats
    // the count reaching zero on the same edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (abort) begin
            state_nxt = SEQ_IDLE;
            cnt_nxt   = '0;
        end else if (hold) begin
            state_nxt = SEQ_HOLD;
            cnt_nxt   = CNT_LOAD;
        end else if (load) begin
            state_nxt = SEQ_COUNT;
            cnt_nxt   = CNT_LOAD;
        end else begin
            unique case (state)
                SEQ_HOLD: begin
                    // The release edge is the first edge of the stretch.
                    state_nxt = SEQ_COUNT;
                    cnt_nxt   = CNT_LOAD;
                end
                SEQ_COUNT: begin
                    if (cnt == '0) begin
                        state_nxt = SEQ_IDLE;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = SEQ_IDLE;
                end
            endcase
        end
    end

    assign active      = (state != SEQ_IDLE);
    assign active_next = (state_nxt != SEQ_IDLE);

endmodule

// File: rtl/tube_ctrl_flags.sv
// tube_ctrl_flags: host register-0 control flags and interrupt/reset
// sequencer of the Tube ULA.
//   h_phi2, rst_b          : host clock, asynchronous active-low reset
//   h_select, h_rdnw       : register-0 select and read/not-write
//   h_data[7:0]            : S in bit 7, flag mask {T,P,V,M,J,I,Q} in 6:0
//   r1/r3/r4_*             : flag-cell status feeding the interrupt lines
//   flags[6:0]             : {T,P,V,M,J,I,Q} readback
//   v_two_byte             : V copy to the register-3 cells
//   fifo_clr_b             : active-low clear of all flag cells
//   p_rst_b                : active-low parasite reset
//   h_irq_b/p_irq_b/p_nmi_b: registered active-low interrupt lines
module tube_ctrl_flags
    import tube_pkg::*;
#(
    parameter int RST_STRETCH = RST_STRETCH_DEF,
    parameter int CLR_CYCLES  = CLR_CYCLES_DEF
) (
    input  logic                 h_phi2,
    input  logic                 rst_b,
    input  logic                 h_select,
    input  logic                 h_rdnw,
    input  logic [7:0]           h_data,
    input  logic                 r1_p_data_avail,
    input  logic                 r3_p_data_avail,
    input  logic                 r3_p_two_bytes,
    input  logic                 r3_h_not_full,
    input  logic                 r4_p_data_avail,
    input  logic                 r4_h_data_avail,
    output logic [NUM_FLAGS-1:0] flags,
    output logic                 v_two_byte,
    output logic                 fifo_clr_b,
    output logic                 p_rst_b,
    output logic                 h_irq_b,
    output logic                 p_irq_b,
    output logic                 p_nmi_b
);

    logic                 wr_en;
    logic                 t_load, t_abort;
    logic [NUM_FLAGS-1:0] flg_p0, flg_nxt;
    logic                 clr_active, clr_active_nxt;
    logic                 rst_active, rst_active_nxt;
    logic                 irq_force_nxt;
    logic                 h_irq_b_p1, p_irq_b_p1, p_nmi_b_p1;
    logic                 r3_ready;

    assign wr_en   = h_select & ~h_rdnw;
    assign t_load  = wr_en & h_data[FLG_T] &  h_data[7];
    assign t_abort = wr_en & h_data[FLG_T] & ~h_data[7];

    // T self-clears when the clear pulse ends; a T write on that edge
    // never ends the pulse, so the write always wins.
    always_comb begin
        flg_nxt = flg_p0;
        if (wr_en) begin
            flg_nxt = apply_write(flg_p0, h_data);
        end
        if (clr_active && !clr_active_nxt) begin
            flg_nxt[FLG_T] = 1'b0;
        end
    end

    // ---- stage p0: flag register ----
    always_ff @(posedge h_phi2 or negedge rst_b) begin
        if (!rst_b) begin
            flg_p0 <= '0;
        end else begin
            flg_p0 <= flg_nxt;
        end
    end

    tube_pulse_stretch #(
        .CYCLES  (CLR_CYCLES),
        .RST_CNT (0)
    ) u_clr_seq (
        .clk         (h_phi2),
        .rst_b       (rst_b),
        .hold        (1'b0),
        .load        (t_load),
        .abort       (t_abort),
        .active      (clr_active),
        .active_next (clr_active_nxt)
    );

    // The hold input follows the next P value so that setting P pulls
    // p_rst_b low on the very edge that samples the write.
    tube_pulse_stretch #(
        .CYCLES  (RST_STRETCH),
        .RST_CNT (RST_STRETCH - 1)
    ) u_rst_seq (
        .clk         (h_phi2),
        .rst_b       (rst_b),
        .hold        (flg_nxt[FLG_P]),
        .load        (1'b0),
        .abort       (1'b0),
        .active      (rst_active),
        .active_next (rst_active_nxt)
    );

    // Forcing uses the next sequencer state so the lines go high on the
    // same edge that starts a clear or parasite reset.
    assign irq_force_nxt = clr_active_nxt | rst_active_nxt;
    assign r3_ready      = (flg_p0[FLG_V] ? r3_p_two_bytes : r3_p_data_avail) | r3_h_not_full;

    // ---- stage p1: registered interrupt lines ----
    always_ff @(posedge h_phi2 or negedge rst_b) begin
        if (!rst_b) begin
            h_irq_b_p1 <= 1'b1;
            p_irq_b_p1 <= 1'b1;
            p_nmi_b_p1 <= 1'b1;
        end else begin
            h_irq_b_p1 <= irq_force_nxt | ~(flg_p0[FLG_J] & r4_h_data_avail);
            p_irq_b_p1 <= irq_force_nxt | ~((flg_p0[FLG_Q] & r1_p_data_avail) |
                                            (flg_p0[FLG_I] & r4_p_data_avail));
            p_nmi_b_p1 <= irq_force_nxt | ~(flg_p0[FLG_M] & r3_ready);
        end
    end

    assign flags      = flg_p0;
    assign v_two_byte = flg_p0[FLG_V];
    assign fifo_clr_b = ~clr_active;
    assign p_rst_b    = ~rst_active;
    assign h_irq_b    = h_irq_b_p1;
    assign p_irq_b    = p_irq_b_p1;
    assign p_nmi_b    = p_nmi_b_p1;

endmodule

// File: tb/tb_tube_ctrl_flags.sv
module tb_tube_ctrl_flags;

    logic       h_phi2 = 1'b0;
    logic       rst_b = 1'b0;
    logic       h_select = 1'b0;
    logic       h_rdnw = 1'b1;
    logic [7:0] h_data = 8'h00;
    logic       r1_p_data_avail = 1'b0;
    logic       r3_p_data_avail = 1'b0;
    logic       r3_p_two_bytes = 1'b0;
    logic       r3_h_not_full = 1'b0;
    logic       r4_p_data_avail = 1'b0;
    logic       r4_h_data_avail = 1'b0;
    logic [6:0] flags;
    logic       v_two_byte, fifo_clr_b, p_rst_b, h_irq_b, p_irq_b, p_nmi_b;

    int total = 0;
    int bad = 0;

    tube_ctrl_flags #(.RST_STRETCH(8), .CLR_CYCLES(2)) dut (
        .h_phi2          (h_phi2),
        .rst_b           (rst_b),
        .h_select        (h_select),
        .h_rdnw          (h_rdnw),
        .h_data          (h_data),
        .r1_p_data_avail (r1_p_data_avail),
        .r3_p_data_avail (r3_p_data_avail),
        .r3_p_two_bytes  (r3_p_two_bytes),
        .r3_h_not_full   (r3_h_not_full),
        .r4_p_data_avail (r4_p_data_avail),
        .r4_h_data_avail (r4_h_data_avail),
        .flags           (flags),
        .v_two_byte      (v_two_byte),
        .fifo_clr_b      (fifo_clr_b),
        .p_rst_b         (p_rst_b),
        .h_irq_b         (h_irq_b),
        .p_irq_b         (p_irq_b),
        .p_nmi_b         (p_nmi_b)
    );

    always #5 h_phi2 = ~h_phi2;

    task automatic tick();
        @(posedge h_phi2);
        #1;
    endtask

    task automatic do_write(input logic [7:0] d);
        h_select = 1'b1;
        h_rdnw   = 1'b0;
        h_data   = d;
        tick();
        h_select = 1'b0;
        h_rdnw   = 1'b1;
        h_data   = 8'h00;
    endtask

    task automatic test_reset();
        logic exp_p;
        rst_b = 1'b0;
        repeat (3) tick();
        total++; if (flags !== 7'h00) begin bad++; $display("FAIL rst_flags got=%h want=00", flags); end
        total++; if (v_two_byte !== 1'b0) begin bad++; $display("FAIL rst_v got=%b want=0", v_two_byte); end
        total++; if (fifo_clr_b !== 1'b0) begin bad++; $display("FAIL rst_fifo_clr got=%b want=0", fifo_clr_b); end
        total++; if (p_rst_b !== 1'b0) begin bad++; $display("FAIL rst_p_rst got=%b want=0", p_rst_b); end
        total++; if ({h_irq_b, p_irq_b, p_nmi_b} !== 3'b111) begin bad++; $display("FAIL rst_irqs got=%b want=111", {h_irq_b, p_irq_b, p_nmi_b}); end
        rst_b = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) begin
                total++; if (fifo_clr_b !== 1'b1) begin bad++; $display("FAIL rel_fifo_clr got=%b want=1", fifo_clr_b); end
            end
            exp_p = (i == 8);
            total++; if (p_rst_b !== exp_p) begin bad++; $display("FAIL rel_p_rst edge=%0d got=%b want=%b", i, p_rst_b, exp_p); end
        end
        total++; if (flags !== 7'h00) begin bad++; $display("FAIL rel_flags got=%h want=00", flags); end
    endtask

    task automatic test_nmi();
        do_write(8'h88);
        do_write(8'h90);
        total++; if (flags !== 7'h18) begin bad++; $display("FAIL mv_flags got=%h want=18", flags); end
        total++; if (v_two_byte !== 1'b1) begin bad++; $display("FAIL mv_vtwo got=%b want=1", v_two_byte); end
        r3_p_data_avail = 1'b1;
        r3_p_two_bytes  = 1'b0;
        tick(); tick();
        total++; if (p_nmi_b !== 1'b1) begin bad++; $display("FAIL nmi_one_byte got=%b want=1", p_nmi_b); end
        r3_p_two_bytes = 1'b1;
        #1;
        total++; if (p_nmi_b !== 1'b1) begin bad++; $display("FAIL nmi_latency got=%b want=1", p_nmi_b); end
        tick();
        total++; if (p_nmi_b !== 1'b0) begin bad++; $display("FAIL nmi_two_bytes got=%b want=0", p_nmi_b); end
        r3_p_two_bytes = 1'b0;
        r3_h_not_full  = 1'b1;
        tick();
        total++; if (p_nmi_b !== 1'b0) begin bad++; $display("FAIL nmi_not_full got=%b want=0", p_nmi_b); end
        r3_h_not_full  = 1'b0;
        tick();
        total++; if (p_nmi_b !== 1'b1) begin bad++; $display("FAIL nmi_release got=%b want=1", p_nmi_b); end
        r3_p_two_bytes = 1'b1;
        tick();
    endtask

    task automatic test_clear();
        // NMI source is active here, so the forcing is observable.
        do_write(8'hC0);
        total++; if (fifo_clr_b !== 1'b0) begin bad++; $display("FAIL clr_e0 got=%b want=0", fifo_clr_b); end
        total++; if (flags !== 7'h58) begin bad++; $display("FAIL clr_t_set got=%h want=58", flags); end
        total++; if (p_nmi_b !== 1'b1) begin bad++; $display("FAIL clr_nmi_e0 got=%b want=1", p_nmi_b); end
        tick();
        total++; if (fifo_clr_b !== 1'b0) begin bad++; $display("FAIL clr_e1 got=%b want=0", fifo_clr_b); end
        total++; if (p_nmi_b !== 1'b1) begin bad++; $display("FAIL clr_nmi_e1 got=%b want=1", p_nmi_b); end
        tick();
        total++; if (fifo_clr_b !== 1'b1) begin bad++; $display("FAIL clr_e2 got=%b want=1", fifo_clr_b); end
        total++; if (flags !== 7'h18) begin bad++; $display("FAIL clr_t_auto got=%h want=18", flags); end
        total++; if (p_nmi_b !== 1'b0) begin bad++; $display("FAIL clr_nmi_after got=%b want=0", p_nmi_b); end
        // reload: second T write one edge in extends the pulse
        do_write(8'hC0);
        do_write(8'hC0);
        tick();
        total++; if (fifo_clr_b !== 1'b0) begin bad++; $display("FAIL reload_hold got=%b want=0", fifo_clr_b); end
        tick();
        total++; if (fifo_clr_b !== 1'b1) begin bad++; $display("FAIL reload_end got=%b want=1", fifo_clr_b); end
        // abort: T with S=0 during CLR
        do_write(8'hC0);
        do_write(8'h40);
        total++; if (fifo_clr_b !== 1'b1) begin bad++; $display("FAIL abort_clr got=%b want=1", fifo_clr_b); end
        total++; if (flags !== 7'h18) begin bad++; $display("FAIL abort_flags got=%h want=18", flags); end
        r3_p_data_avail = 1'b0;
        r3_p_two_bytes  = 1'b0;
        tick();
    endtask

    task automatic test_parasite_reset();
        logic exp_p;
        do_write(8'hA0);
        total++; if (p_rst_b !== 1'b0) begin bad++; $display("FAIL prst_set got=%b want=0", p_rst_b); end
        total++; if (flags !== 7'h38) begin bad++; $display("FAIL prst_flags got=%h want=38", flags); end
        repeat (4) tick();
        do_write(8'h20);
        total++; if (p_rst_b !== 1'b0) begin bad++; $display("FAIL prst_clr_edge got=%b want=0", p_rst_b); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_p = (i == 8);
            total++; if (p_rst_b !== exp_p) begin bad++; $display("FAIL prst_stretch edge=%0d got=%b want=%b", i, p_rst_b, exp_p); end
        end
        // P re-set mid-stretch restarts the full stretch
        do_write(8'hA0);
        do_write(8'h20);
        repeat (4) tick();
        do_write(8'hA0);
        do_write(8'h20);
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_p = (i == 8);
            total++; if (p_rst_b !== exp_p) begin bad++; $display("FAIL prst_restart edge=%0d got=%b want=%b", i, p_rst_b, exp_p); end
        end
    endtask

    task automatic test_irq();
        do_write(8'h85);
        total++; if (flags !== 7'h1D) begin bad++; $display("FAIL irq_flags got=%h want=1d", flags); end
        r1_p_data_avail = 1'b1;
        tick();
        total++; if (p_irq_b !== 1'b0) begin bad++; $display("FAIL pirq_on got=%b want=0", p_irq_b); end
        r1_p_data_avail = 1'b0;
        #1;
        total++; if (p_irq_b !== 1'b0) begin bad++; $display("FAIL pirq_latency got=%b want=0", p_irq_b); end
        tick();
        total++; if (p_irq_b !== 1'b1) begin bad++; $display("FAIL pirq_off got=%b want=1", p_irq_b); end
        r4_h_data_avail = 1'b1;
        r4_p_data_avail = 1'b1;
        tick();
        total++; if (h_irq_b !== 1'b0) begin bad++; $display("FAIL hirq_on got=%b want=0", h_irq_b); end
        total++; if (p_irq_b !== 1'b1) begin bad++; $display("FAIL pirq_i_clear got=%b want=1", p_irq_b); end
        r4_p_data_avail = 1'b0;
        r1_p_data_avail = 1'b1;
        tick();
        do_write(8'h05);
        total++; if ({h_irq_b, p_irq_b} !== 2'b00) begin bad++; $display("FAIL irq_clr_latency got=%b want=00", {h_irq_b, p_irq_b}); end
        tick();
        total++; if ({h_irq_b, p_irq_b} !== 2'b11) begin bad++; $display("FAIL irq_clr got=%b want=11", {h_irq_b, p_irq_b}); end
    endtask

    task automatic test_async_reset();
        r1_p_data_avail = 1'b0;
        r4_h_data_avail = 1'b0;
        // part A: live interrupt cleared by reset without a clock
        do_write(8'h81);
        r1_p_data_avail = 1'b1;
        tick();
        total++; if (p_irq_b !== 1'b0) begin bad++; $display("FAIL ar_pre_irq got=%b want=0", p_irq_b); end
        #3 rst_b = 1'b0;
        #1;
        total++; if (p_irq_b !== 1'b1) begin bad++; $display("FAIL ar_irq got=%b want=1", p_irq_b); end
        total++; if (flags !== 7'h00) begin bad++; $display("FAIL ar_flags_a got=%h want=00", flags); end
        rst_b = 1'b1;
        r1_p_data_avail = 1'b0;
        repeat (8) tick();
        // part B: both sequencers mid-flight
        do_write(8'hA0);
        do_write(8'h20);
        tick();
        do_write(8'hC0);
        total++; if ({fifo_clr_b, p_rst_b} !== 2'b00) begin bad++; $display("FAIL ar_pre_seq got=%b want=00", {fifo_clr_b, p_rst_b}); end
        #3 rst_b = 1'b0;
        #1;
        total++; if (flags !== 7'h00) begin bad++; $display("FAIL ar_flags_b got=%h want=00", flags); end
        total++; if (v_two_byte !== 1'b0) begin bad++; $display("FAIL ar_v got=%b want=0", v_two_byte); end
        total++; if ({fifo_clr_b, p_rst_b} !== 2'b00) begin bad++; $display("FAIL ar_seq got=%b want=00", {fifo_clr_b, p_rst_b}); end
        total++; if ({h_irq_b, p_irq_b, p_nmi_b} !== 3'b111) begin bad++; $display("FAIL ar_irqs got=%b want=111", {h_irq_b, p_irq_b, p_nmi_b}); end
        rst_b = 1'b1;
        tick();
        total++; if (fifo_clr_b !== 1'b1) begin bad++; $display("FAIL ar_rel_clr got=%b want=1", fifo_clr_b); end
        repeat (6) tick();
        total++; if (p_rst_b !== 1'b0) begin bad++; $display("FAIL ar_rel_prst7 got=%b want=0", p_rst_b); end
        tick();
        total++; if (p_rst_b !== 1'b1) begin bad++; $display("FAIL ar_rel_prst8 got=%b want=1", p_rst_b); end
    endtask

    initial begin
        test_reset();
        test_nmi();
        test_clear();
        test_parasite_reset();
        test_irq();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
